// File: rtl/txn_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : txn_seq_pkg
// Description : Shared types and width helpers for the round-robin
//               transaction sequencer and its priority selector.
//               Contents: seq_state_t (IDLE/GRANT/DONE), cnt_width(),
//               idx_width().
// Revision    : 1.0 - initial release
// ============================================================================
package txn_seq_pkg;

    // Sequencer states, explicitly 2 bits wide.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    // Width needed to hold 0..done_count, never less than one bit.
    function automatic int cnt_width(input int done_count);
        return (done_count < 1) ? 1 : $clog2(done_count + 1);
    endfunction

    // Width needed to index n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority selector. Picks the first
//               set request searching upward from (ptr+1) mod N with wrap.
//   req   in  [N-1:0]  request vector
//   ptr   in  [IW-1:0] index granted last (lowest priority this round)
//   pick  out [N-1:0]  one-hot selected request (0 when none)
//   idx   out [IW-1:0] index of the selected request
//   valid out          at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import txn_seq_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int j;
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        // Offsets 1..N visit every index once, ending on ptr itself.
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!valid && req[j]) begin
                valid   = 1'b1;
                pick[j] = 1'b1;
                idx     = IW'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/txn_round_robin_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : txn_round_robin_sequencer
// Description : Grants a shared resource to one of NUM_REQ requesters at a
//               time with round-robin fairness, counts completed
//               transactions up to DONE_COUNT (then sticky done) and forces
//               release of any grant held for MAX_HOLD cycles.
//   clk         in             rising-edge clock
//   reset_l     in             asynchronous active-low reset
//   en          in             allow new grants
//   req         in  [NUM_REQ]  request levels
//   rel         in  [NUM_REQ]  release pulses (only granted index honoured)
//   gnt         out [NUM_REQ]  registered one-hot grant
//   busy        out            grant active
//   txn_count   out [CW]       completed transactions (saturating)
//   done        out            sticky, DONE_COUNT transactions completed
//   timeout_err out            sticky, a grant was forcibly released
// Revision    : 1.0 - initial release
// ============================================================================
module txn_round_robin_sequencer
    import txn_seq_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int DONE_COUNT = 25,
    parameter int MAX_HOLD   = 16
) (
    input  logic                             clk,
    input  logic                             reset_l,
    input  logic                             en,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               rel,
    output logic [NUM_REQ-1:0]               gnt,
    output logic                             busy,
    output logic [cnt_width(DONE_COUNT)-1:0] txn_count,
    output logic                             done,
    output logic                             timeout_err
);

    localparam int c_cw = cnt_width(DONE_COUNT);
    localparam int c_iw = idx_width(NUM_REQ);
    localparam int c_hw = idx_width(MAX_HOLD);

    localparam logic [c_cw-1:0] c_done_cnt = c_cw'(DONE_COUNT);
    localparam logic [c_iw-1:0] c_ptr_rst  = c_iw'(NUM_REQ - 1);
    localparam logic [c_hw-1:0] c_hold_max = c_hw'(MAX_HOLD - 1);

    seq_state_t         r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt,   w_gnt_nxt;
    logic [c_iw-1:0]    r_gidx,  w_gidx_nxt;
    logic [c_iw-1:0]    r_ptr,   w_ptr_nxt;
    logic [c_hw-1:0]    r_hold,  w_hold_nxt;
    logic [c_cw-1:0]    r_cnt,   w_cnt_nxt;
    logic               r_tmo,   w_tmo_nxt;
    logic [c_cw-1:0]    w_cnt_inc;

    logic [NUM_REQ-1:0] w_pick;
    logic [c_iw-1:0]    w_pick_idx;
    logic               w_pick_vld;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (c_iw)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .pick  (w_pick),
        .idx   (w_pick_idx),
        .valid (w_pick_vld)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_ptr   <= c_ptr_rst;
            r_hold  <= '0;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = r_tmo;
        // Saturating increment; the count can never pass DONE_COUNT.
        w_cnt_inc   = (r_cnt == c_done_cnt) ? r_cnt : r_cnt + c_cw'(1);

        case (r_state)
            ST_IDLE: begin
                if (DONE_COUNT == 0) begin
                    w_state_nxt = ST_DONE;
                end else if (en && w_pick_vld) begin
                    w_gnt_nxt   = w_pick;
                    w_gidx_nxt  = w_pick_idx;
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // Release is checked before the watchdog so a release on the
                // expiry cycle is still counted as a normal completion.
                if (rel[r_gidx]) begin
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_gidx;
                    w_hold_nxt  = '0;
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = (w_cnt_inc == c_done_cnt) ? ST_DONE : ST_IDLE;
                end else if (r_hold == c_hold_max) begin
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = r_gidx;
                    w_hold_nxt  = '0;
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt  = r_hold + c_hw'(1);
                end
            end
            ST_DONE: begin
                w_gnt_nxt = '0;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign gnt         = r_gnt;
    assign busy        = (r_state == ST_GRANT);
    assign txn_count   = r_cnt;
    assign done        = (r_state == ST_DONE);
    assign timeout_err = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_txn_round_robin_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_txn_round_robin_sequencer
// Description : Self-checking bench for txn_round_robin_sequencer with
//               NUM_REQ=2, DONE_COUNT=25, MAX_HOLD=16. Expected grants are
//               queued when stimulus is applied and compared as grants appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_txn_round_robin_sequencer;

    localparam int c_done = 25;

    logic       clk = 1'b0;
    logic       reset_l = 1'b0;
    logic       en = 1'b0;
    logic [1:0] req = 2'b00;
    logic [1:0] rel = 2'b00;
    logic [1:0] gnt;
    logic       busy;
    logic [4:0] txn_count;
    logic       done;
    logic       timeout_err;

    int         total = 0;
    int         bad = 0;
    int         exp_cnt = 0;
    logic [1:0] exp_q[$];

    txn_round_robin_sequencer #(
        .NUM_REQ    (2),
        .DONE_COUNT (c_done),
        .MAX_HOLD   (16)
    ) u_dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .en          (en),
        .req         (req),
        .rel         (rel),
        .gnt         (gnt),
        .busy        (busy),
        .txn_count   (txn_count),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("busy_eq_gnt", 32'(busy), 32'(|gnt));
    endtask

    task automatic pop_check(input string tag);
        chk({tag, "_sb_depth"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0)
            chk(tag, 32'(gnt), 32'(exp_q.pop_front()));
    endtask

    // Bounded wait for the next grant, then compare against the scoreboard.
    task automatic wait_grant(input string tag);
        int k = 0;
        while (gnt == 2'b00 && k < 8) begin
            tick();
            k++;
        end
        pop_check(tag);
    endtask

    // Hold the current grant for hold_cyc cycles, then release it.
    task automatic serve(input int hold_cyc);
        logic [1:0] g;
        g = gnt;
        repeat (hold_cyc - 1) tick();
        rel = g;
        tick();
        rel = 2'b00;
        exp_cnt++;
        chk("rel_gnt", 32'(gnt), 32'd0);
        chk("rel_cnt", 32'(txn_count), 32'(exp_cnt));
        if (exp_cnt < c_done)
            exp_q.push_back(~g);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(txn_count), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        tick();
        tick();
        reset_l = 1'b1;
        en = 1'b1;

        // Single requester, illegal release, req drop without release.
        req = 2'b01;
        exp_q.push_back(2'b01);
        tick();
        pop_check("first_gnt");
        rel = 2'b10;
        tick();
        rel = 2'b00;
        chk("illegal_rel_gnt", 32'(gnt), 32'd1);
        chk("illegal_rel_cnt", 32'(txn_count), 32'd0);
        req = 2'b00;
        tick();
        chk("req_drop_gnt", 32'(gnt), 32'd1);
        rel = 2'b01;
        tick();
        rel = 2'b00;
        exp_cnt = 1;
        chk("single_rel_gnt", 32'(gnt), 32'd0);
        chk("single_rel_cnt", 32'(txn_count), 32'd1);

        // Enable gating in IDLE, then one-cycle grant latency.
        en = 1'b0;
        req = 2'b11;
        repeat (3) begin
            tick();
            chk("en_low_gnt", 32'(gnt), 32'd0);
        end
        en = 1'b1;
        exp_q.push_back(2'b10);
        tick();
        pop_check("en_gnt");
        en = 1'b0;
        tick();
        chk("en_fall_hold", 32'(gnt), 32'd2);
        en = 1'b1;
        serve(2);

        // Alternating grants up to seven completions.
        while (exp_cnt < 7) begin
            wait_grant("fair_gnt");
            serve(2);
        end
        wait_grant("pre_reset_gnt");
        chk("pre_reset_cnt", 32'(txn_count), 32'd7);

        // Asynchronous reset in the middle of a grant.
        #2;
        reset_l = 1'b0;
        #1;
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_cnt", 32'(txn_count), 32'd0);
        chk("async_done", 32'(done), 32'd0);
        chk("async_tmo", 32'(timeout_err), 32'd0);
        exp_q.delete();
        exp_cnt = 0;
        tick();
        reset_l = 1'b1;
        exp_q.push_back(2'b01);
        tick();
        pop_check("post_reset_gnt");

        // Release on the watchdog expiry cycle is a normal completion.
        repeat (15) tick();
        rel = 2'b01;
        tick();
        rel = 2'b00;
        exp_cnt = 1;
        chk("race_gnt", 32'(gnt), 32'd0);
        chk("race_cnt", 32'(txn_count), 32'd1);
        chk("race_tmo", 32'(timeout_err), 32'd0);
        exp_q.push_back(2'b10);

        // Watchdog forced release after 16 cycles of grant.
        wait_grant("wd_gnt");
        repeat (15) tick();
        chk("wd_still_held", 32'(gnt), 32'd2);
        tick();
        chk("wd_gnt_drop", 32'(gnt), 32'd0);
        chk("wd_tmo", 32'(timeout_err), 32'd1);
        chk("wd_cnt", 32'(txn_count), 32'd1);
        exp_q.push_back(2'b01);
        wait_grant("after_wd_gnt");

        // Run to DONE_COUNT completions.
        while (exp_cnt < c_done) begin
            serve(2);
            if (exp_cnt < c_done)
                wait_grant("fair2_gnt");
        end
        chk("done_set", 32'(done), 32'd1);
        repeat (5) tick();
        chk("done_gnt", 32'(gnt), 32'd0);
        chk("done_sticky", 32'(done), 32'd1);
        chk("done_cnt", 32'(txn_count), 32'(c_done));
        chk("done_busy", 32'(busy), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
